// File: rtl/llki_tl_arbiter.sv
// Round-robin arbiter letting several TL-UL masters share one LLKI-PP slave.
// Allows one outstanding transaction and synthesizes a denied response if the slave stalls.
package llki_tl_pkg;
    localparam logic [2:0] OpPutFullData    = 3'd0;
    localparam logic [2:0] OpPutPartialData = 3'd1;
    localparam logic [2:0] OpGet            = 3'd4;
    localparam logic [2:0] OpAccessAck      = 3'd0;
    localparam logic [2:0] OpAccessAckData  = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_chA_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_size;
        logic [7:0]  d_source;
        logic        d_denied;
        logic        d_corrupt;
        logic [31:0] d_data;
        logic        a_ready;
    } tl_chD_t;
endpackage

module llki_tl_arbiter
    import llki_tl_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TIMEOUT     = 256,
    localparam int unsigned IdW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  tl_chA_t [NUM_MASTERS-1:0] m_chA,
    output tl_chD_t [NUM_MASTERS-1:0] m_chD,
    output tl_chA_t                   s_chA,
    input  tl_chD_t                   s_chD,
    output logic [IdW-1:0]            grant_id,
    output logic                      busy,
    output logic                      timeout_err,
    input  logic                      err_clr
);
    typedef enum logic [1:0] {StIdle, StAddr, StData, StTout} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_e         state_q, state_d;
    logic [IdW-1:0] grant_q, grant_d;
    logic [IdW-1:0] last_grant_q, last_grant_d;
    logic [IdW-1:0] rr_pick;
    logic           rr_found;
    logic [15:0]    cnt_q, cnt_d;
    logic [7:0]     src_q, src_d;
    logic [2:0]     size_q, size_d;
    logic [2:0]     opc_q, opc_d;
    logic           terr_q, terr_d;
    logic           terr_set;
    tl_chA_t        req;

    assign req = m_chA[grant_q];

    // Search starts just past the last completed grant so every master gets a turn.
    always_comb begin
        rr_pick  = last_grant_q;
        rr_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            int unsigned idx;
            idx = (32'(last_grant_q) + k) % NUM_MASTERS;
            if (!rr_found && m_chA[IdW'(idx)].a_valid) begin
                rr_pick  = IdW'(idx);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        src_d        = src_q;
        size_d       = size_q;
        opc_d        = opc_q;
        terr_set     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (!req.a_valid) begin
                    state_d = StIdle;
                end else if (s_chD.a_ready) begin
                    src_d   = req.a_source;
                    size_d  = req.a_size;
                    opc_d   = req.a_opcode;
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (s_chD.d_valid) begin
                    if (req.d_ready) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == CntLast) begin
                        state_d = StTout;
                    end
                end
            end
            StTout: begin
                if (req.d_ready) begin
                    terr_set     = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        terr_d = terr_set | (terr_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= IdW'(NUM_MASTERS - 1);
            cnt_q        <= '0;
            src_q        <= '0;
            size_q       <= '0;
            opc_q        <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            src_q        <= src_d;
            size_q       <= size_d;
            opc_q        <= opc_d;
            terr_q       <= terr_d;
        end
    end

    // Outputs are forced to their reset values for as long as rst is held.
    always_comb begin
        s_chA = '0;
        m_chD = '0;
        if (!rst) begin
            unique case (state_q)
                StAddr: begin
                    s_chA                  = req;
                    s_chA.d_ready          = 1'b0;
                    m_chD[grant_q].a_ready = s_chD.a_ready;
                end
                StData: begin
                    s_chA.d_ready            = req.d_ready;
                    m_chD[grant_q].d_valid   = s_chD.d_valid;
                    m_chD[grant_q].d_opcode  = s_chD.d_opcode;
                    m_chD[grant_q].d_size    = s_chD.d_size;
                    m_chD[grant_q].d_source  = s_chD.d_source;
                    m_chD[grant_q].d_denied  = s_chD.d_denied;
                    m_chD[grant_q].d_data    = s_chD.d_data;
                    m_chD[grant_q].d_corrupt = s_chD.d_corrupt |
                                               (s_chD.d_valid && (s_chD.d_source != src_q));
                end
                StTout: begin
                    s_chA.d_ready           = 1'b1;
                    m_chD[grant_q].d_valid  = 1'b1;
                    m_chD[grant_q].d_denied = 1'b1;
                    m_chD[grant_q].d_source = src_q;
                    m_chD[grant_q].d_size   = size_q;
                    m_chD[grant_q].d_opcode = (opc_q == OpGet) ? OpAccessAckData : OpAccessAck;
                end
                default: ;
            endcase
        end
    end

    assign grant_id    = rst ? '0 : grant_q;
    assign busy        = !rst && (state_q != StIdle);
    assign timeout_err = !rst && terr_q;

endmodule

// File: tb/tb_llki_tl_arbiter.sv
// Directed bench for llki_tl_arbiter: round-robin order, slave back-pressure,
// watchdog timeout, source-mismatch corruption and mid-transaction reset.
module tb_llki_tl_arbiter;
    import llki_tl_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          err_clr = 1'b0;
    tl_chA_t [3:0] m_cha;
    tl_chD_t [3:0] m_chd;
    tl_chA_t       s_cha;
    tl_chD_t       s_chd;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_errs   = 0;
    int grants [4] = '{default: 0};
    int cyc;
    int g;
    tl_chA_t exp_a;

    llki_tl_arbiter #(
        .NUM_MASTERS(4),
        .TIMEOUT    (16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .m_chA      (m_cha),
        .m_chD      (m_chd),
        .s_chA      (s_cha),
        .s_chD      (s_chd),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        m_cha           = '0;
        s_chd           = '0;
        s_chd.a_ready   = 1'b1;
        err_clr         = 1'b0;
        step();
        rst             = 1'b0;
    endtask

    task automatic req(input int m, input logic [2:0] opc, input logic [7:0] src,
                       input logic [2:0] sz);
        m_cha[m].a_valid   = 1'b1;
        m_cha[m].a_opcode  = opc;
        m_cha[m].a_source  = src;
        m_cha[m].a_size    = sz;
        m_cha[m].a_address = 32'h1000 + 32'(m * 4);
        m_cha[m].a_mask    = 4'hf;
        m_cha[m].a_data    = 32'ha0 + 32'(m);
        m_cha[m].d_ready   = 1'b1;
    endtask

    task automatic respond(input logic [7:0] src, input logic [2:0] opc, input logic [31:0] data);
        s_chd.d_valid  = 1'b1;
        s_chd.d_source = src;
        s_chd.d_opcode = opc;
        s_chd.d_size   = 3'd2;
        s_chd.d_data   = data;
    endtask

    // Master 1 must already be requesting; returns cycles from accept until the denied response.
    task automatic run_to_tout(output int n);
        step();
        step();
        m_cha[1].a_valid = 1'b0;
        settle();
        n = 0;
        while (n < 40 && !m_chd[1].d_denied) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_cha         = '0;
        s_chd         = '0;
        s_chd.a_ready = 1'b1;
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_s_cha_zero", 32'(s_cha == '0), 1);
        check("rst_m_chd_zero", 32'(m_chd == '0), 1);
        rst = 1'b0;

        // Masters 0 and 2 request together.
        req(0, OpPutFullData, 8'h00, 3'd2);
        req(2, OpPutFullData, 8'h02, 3'd2);
        settle();
        check("idle_no_fwd", s_cha.a_valid, 0);
        step();
        check("p02_grant0", grant_id, 0);
        check("p02_busy", busy, 1);
        check("p02_s_src", s_cha.a_source, 8'h00);
        check("p02_s_dready", s_cha.d_ready, 0);
        check("p02_m0_ardy", m_chd[0].a_ready, 1);
        check("p02_m2_zero", 32'(m_chd[2] == '0), 1);
        step();
        m_cha[0].a_valid = 1'b0;
        respond(8'h00, OpAccessAck, 32'h0);
        settle();
        check("p02_data_avalid", s_cha.a_valid, 0);
        check("p02_data_dready", s_cha.d_ready, 1);
        check("p02_m0_dvalid", m_chd[0].d_valid, 1);
        check("p02_m0_opc", m_chd[0].d_opcode, OpAccessAck);
        check("p02_m0_corrupt", m_chd[0].d_corrupt, 0);
        check("p02_m2_zero_b", 32'(m_chd[2] == '0), 1);
        step();
        s_chd.d_valid = 1'b0;
        settle();
        check("p02_gap_idle", busy, 0);
        step();
        check("p02_grant2", grant_id, 2);
        check("p02_s_src2", s_cha.a_source, 8'h02);
        step();
        m_cha[2].a_valid = 1'b0;
        respond(8'h02, OpAccessAck, 32'h0);
        settle();
        check("p02_m2_dvalid", m_chd[2].d_valid, 1);
        check("p02_m0_zero", 32'(m_chd[0] == '0), 1);
        step();
        s_chd.d_valid = 1'b0;

        // All four masters continuously requesting.
        do_reset();
        for (int m = 0; m < 4; m++) req(m, OpPutFullData, 8'(8'h20 + m), 3'd2);
        for (int t = 0; t < 8; t++) begin
            step();
            check("rr_order", grant_id, 32'(t % 4));
            g = int'(grant_id);
            grants[g]++;
            step();
            respond(m_cha[g].a_source, OpAccessAck, 32'h0);
            settle();
            check("rr_rsp", m_chd[g].d_valid, 1);
            step();
            s_chd.d_valid = 1'b0;
        end
        for (int m = 0; m < 4; m++) check("rr_count", grants[m], 2);

        // Slave back-pressure for five cycles.
        do_reset();
        s_chd.a_ready = 1'b0;
        req(1, OpPutFullData, 8'h31, 3'd2);
        req(3, OpPutFullData, 8'h33, 3'd2);
        exp_a         = m_cha[1];
        exp_a.d_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_s_cha", 32'(s_cha == exp_a), 1);
            check("stall_ardy", m_chd[1].a_ready, 0);
            step();
        end
        s_chd.a_ready = 1'b1;
        settle();
        check("stall_grant", grant_id, 1);
        check("stall_m1_ardy", m_chd[1].a_ready, 1);
        check("stall_m3_ardy", m_chd[3].a_ready, 0);
        step();
        m_cha[1].a_valid = 1'b0;
        m_cha[3].a_valid = 1'b0;
        respond(8'h31, OpAccessAck, 32'h0);
        step();
        s_chd.d_valid = 1'b0;

        // Watchdog: Get from master 1 never answered.
        do_reset();
        req(1, OpGet, 8'h11, 3'd3);
        m_cha[1].d_ready = 1'b0;
        run_to_tout(cyc);
        check("tout_latency", cyc, 15);
        check("tout_dvalid", m_chd[1].d_valid, 1);
        check("tout_denied", m_chd[1].d_denied, 1);
        check("tout_source", m_chd[1].d_source, 8'h11);
        check("tout_size", m_chd[1].d_size, 3);
        check("tout_opcode", m_chd[1].d_opcode, OpAccessAckData);
        check("tout_terr_early", timeout_err, 0);
        respond(8'h11, OpAccessAckData, 32'hdead);
        settle();
        check("tout_data_zero", m_chd[1].d_data, 0);
        check("tout_drain", s_cha.d_ready, 1);
        m_cha[1].d_ready = 1'b1;
        step();
        s_chd.d_valid = 1'b0;
        settle();
        check("tout_terr_set", timeout_err, 1);
        check("tout_idle", busy, 0);
        check("tout_m1_zero", 32'(m_chd[1] == '0), 1);
        step();
        check("tout_terr_sticky", timeout_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tout_terr_clr", timeout_err, 0);

        // Set and clear in the same cycle: set wins.
        req(1, OpGet, 8'h11, 3'd3);
        m_cha[1].d_ready = 1'b0;
        run_to_tout(cyc);
        check("tout2_latency", cyc, 15);
        m_cha[1].d_ready = 1'b1;
        err_clr          = 1'b1;
        step();
        err_clr = 1'b0;
        check("tout2_set_wins", timeout_err, 1);

        // Response source mismatch.
        do_reset();
        req(0, OpPutFullData, 8'h03, 3'd2);
        step();
        step();
        m_cha[0].a_valid = 1'b0;
        respond(8'h05, OpAccessAck, 32'h1234);
        settle();
        check("mis_corrupt", m_chd[0].d_corrupt, 1);
        check("mis_source", m_chd[0].d_source, 8'h05);
        check("mis_data", m_chd[0].d_data, 32'h1234);
        step();
        s_chd.d_valid = 1'b0;

        // Reset during DATA.
        do_reset();
        req(2, OpPutFullData, 8'h22, 3'd2);
        step();
        step();
        m_cha[2].a_valid = 1'b0;
        settle();
        check("mrst_busy_before", busy, 1);
        rst = 1'b1;
        settle();
        check("mrst_busy_in_rst", busy, 0);
        step();
        rst = 1'b0;
        settle();
        check("mrst_busy", busy, 0);
        check("mrst_grant", grant_id, 0);
        check("mrst_s_cha_zero", 32'(s_cha == '0), 1);
        check("mrst_m_chd_zero", 32'(m_chd == '0), 1);
        req(2, OpPutFullData, 8'h22, 3'd2);
        step();
        check("mrst_regrant", grant_id, 2);
        step();
        m_cha[2].a_valid = 1'b0;
        respond(8'h22, OpAccessAck, 32'h0);
        settle();
        check("mrst_rsp", m_chd[2].d_valid, 1);
        check("mrst_rsp_corrupt", m_chd[2].d_corrupt, 0);
        step();
        s_chd.d_valid = 1'b0;
        settle();
        check("mrst_done", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
